despread_code_gen: RTL and testbench

- 18-bit PN code generator for one despreader channel (A or B); one instance per channel.
- Consumes the channel's code configuration from the despreader register block: init, polyTaps, codeRestartCount, iOutTaps, qOutTaps, epoch, goldEnable, and the slip request.
- Produces chip-rate I/Q code bits, a code-epoch strobe and a chip index for the downstream correlator.
- Returns the `slipped` acknowledge that clears the register block's slip request.

---
 rtl/despread_code_gen.sv | 151 +++++++++++++++
 tb/tb_despread_code_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/despread_code_gen.sv
// PN code generator for one despreader channel: Fibonacci LFSR with tap-mask
// outputs, programmable restart, epoch strobe and a single-chip slip handshake.
module despread_code_gen #(
  parameter int LFSR_BITS  = 18,
  parameter int SLIP_CHIPS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 chipEn,
  input  logic [LFSR_BITS-1:0] init,
  input  logic [LFSR_BITS-1:0] polyTaps,
  input  logic [LFSR_BITS-1:0] codeRestartCount,
  input  logic [LFSR_BITS-1:0] iOutTaps,
  input  logic [LFSR_BITS-1:0] qOutTaps,
  input  logic [LFSR_BITS-1:0] epoch,
  input  logic                 goldEnable,
  input  logic                 slip,
  output logic                 iCode,
  output logic                 qCode,
  output logic                 chipValid,
  output logic                 codeEpoch,
  output logic [LFSR_BITS-1:0] chipIndex,
  output logic                 slipped
);

  localparam int HOLD_W = (SLIP_CHIPS < 1) ? 1 : $clog2(SLIP_CHIPS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } slip_state_t;

  slip_state_t          state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [LFSR_BITS-1:0] sr_q, sr_d;
  logic [LFSR_BITS-1:0] count_q, count_d;
  logic                 icode_q, icode_d;
  logic                 qcode_q, qcode_d;
  logic                 chip_valid_q, chip_valid_d;
  logic                 code_epoch_q, code_epoch_d;
  logic [LFSR_BITS-1:0] chip_index_q, chip_index_d;
  logic                 slipped_q, slipped_d;

  logic fb, pi, pq, hold, advance;

  always_comb begin
    fb      = ^(sr_q & polyTaps);
    pi      = ^(sr_q & iOutTaps);
    pq      = ^(sr_q & qOutTaps);
    // A pending slip swallows whole chip enables, including a restart chip.
    hold    = (state_q == PEND);
    advance = chipEn & ~hold;
  end

  always_comb begin
    sr_d         = sr_q;
    count_d      = count_q;
    icode_d      = icode_q;
    qcode_d      = qcode_q;
    chip_index_d = chip_index_q;
    chip_valid_d = 1'b0;
    code_epoch_d = 1'b0;

    if (advance) begin
      icode_d      = goldEnable ? (pi ^ pq) : pi;
      qcode_d      = pq;
      chip_index_d = count_q;
      code_epoch_d = (count_q == epoch);
      chip_valid_d = 1'b1;
      if (count_q == codeRestartCount) begin
        sr_d    = init;
        count_d = '0;
      end else begin
        sr_d    = {sr_q[LFSR_BITS-2:0], fb};
        count_d = count_q + LFSR_BITS'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    slipped_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (slip) begin
          state_d    = PEND;
          hold_cnt_d = HOLD_W'(SLIP_CHIPS);
        end
      end
      PEND: begin
        if (chipEn) begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          if (hold_cnt_q == HOLD_W'(1)) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        slipped_d = 1'b1;
        state_d   = WAIT_LOW;
      end
      WAIT_LOW: begin
        // Wait for the request to drop so a slow clear cannot re-trigger.
        if (!slip) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      sr_q         <= init;
      count_q      <= '0;
      icode_q      <= 1'b0;
      qcode_q      <= 1'b0;
      chip_valid_q <= 1'b0;
      code_epoch_q <= 1'b0;
      chip_index_q <= '0;
      slipped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      sr_q         <= sr_d;
      count_q      <= count_d;
      icode_q      <= icode_d;
      qcode_q      <= qcode_d;
      chip_valid_q <= chip_valid_d;
      code_epoch_q <= code_epoch_d;
      chip_index_q <= chip_index_d;
      slipped_q    <= slipped_d;
    end
  end

  assign iCode     = icode_q;
  assign qCode     = qcode_q;
  assign chipValid = chip_valid_q;
  assign codeEpoch = code_epoch_q;
  assign chipIndex = chip_index_q;
  assign slipped   = slipped_q;

endmodule

// File: tb/tb_despread_code_gen.sv
// Bench for despread_code_gen: directed code/slip scenarios plus randomized
// traffic, all checked against a chip-level behavioural model.
module tb_despread_code_gen;

  localparam int SLIP_CHIPS = 1;

  logic        clk = 1'b0;
  logic        reset, chipEn, goldEnable, slip;
  logic [17:0] init, polyTaps, codeRestartCount, iOutTaps, qOutTaps, epoch;
  logic        iCode, qCode, chipValid, codeEpoch, slipped;
  logic [17:0] chipIndex;

  despread_code_gen #(.LFSR_BITS(18), .SLIP_CHIPS(SLIP_CHIPS)) dut (
    .clk(clk), .reset(reset), .chipEn(chipEn), .init(init), .polyTaps(polyTaps),
    .codeRestartCount(codeRestartCount), .iOutTaps(iOutTaps), .qOutTaps(qOutTaps),
    .epoch(epoch), .goldEnable(goldEnable), .slip(slip),
    .iCode(iCode), .qCode(qCode), .chipValid(chipValid), .codeEpoch(codeEpoch),
    .chipIndex(chipIndex), .slipped(slipped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model: code state plus slip bookkeeping in plain terms.
  logic [17:0] m_sr, m_count;
  int          m_hold_left;   // held chip enables still owed to a slip
  bit          m_ack_due;     // acknowledge goes out on the next clock
  bit          m_await_drop;  // acknowledged, waiting for slip to fall
  bit          e_i, e_q, e_valid, e_epoch, e_slipped;
  logic [17:0] e_idx;

  function automatic bit parity(input logic [17:0] v);
    return bit'($countones(v) % 2);
  endfunction

  task automatic model_clock();
    bit held, pi, pq;
    if (reset) begin
      m_sr = init; m_count = '0; m_hold_left = 0; m_ack_due = 0; m_await_drop = 0;
      e_i = 0; e_q = 0; e_valid = 0; e_epoch = 0; e_slipped = 0; e_idx = '0;
      return;
    end
    held      = (m_hold_left > 0) && chipEn;
    e_valid   = 0;
    e_epoch   = 0;
    e_slipped = 0;
    if (chipEn && !held) begin
      pi      = parity(m_sr & iOutTaps);
      pq      = parity(m_sr & qOutTaps);
      e_i     = goldEnable ? (pi ^ pq) : pi;
      e_q     = pq;
      e_idx   = m_count;
      e_epoch = (m_count == epoch);
      e_valid = 1;
      if (m_count == codeRestartCount) begin
        m_sr = init; m_count = '0;
      end else begin
        m_sr = {m_sr[16:0], parity(m_sr & polyTaps)};
        m_count = m_count + 18'd1;
      end
    end
    if (m_ack_due) begin
      e_slipped = 1; m_ack_due = 0; m_await_drop = 1;
    end else if (m_hold_left > 0) begin
      if (chipEn) begin
        m_hold_left--;
        if (m_hold_left == 0) m_ack_due = 1;
      end
    end else if (m_await_drop) begin
      if (!slip) m_await_drop = 0;
    end else if (slip) begin
      m_hold_left = SLIP_CHIPS;
    end
  endtask

  typedef struct {bit i; bit q; bit ep; int idx;} chip_t;
  chip_t chips[$];
  int    slip_acks;

  // One clock: predict, advance, compare every output, log emitted chips.
  task automatic step();
    chip_t c;
    model_clock();
    @(posedge clk);
    #1;
    check("chipValid", chipValid, e_valid);
    check("codeEpoch", codeEpoch, e_epoch);
    check("slipped",   slipped,   e_slipped);
    check("iCode",     iCode,     e_i);
    check("qCode",     qCode,     e_q);
    check("chipIndex", chipIndex, e_idx);
    if (slipped) slip_acks++;
    if (chipValid) begin
      c.i = iCode; c.q = qCode; c.ep = codeEpoch; c.idx = int'(chipIndex);
      chips.push_back(c);
      $display("chip idx=%0d i=%0b q=%0b epoch=%0b t=%0t", chipIndex, iCode, qCode, codeEpoch, $time);
    end
  endtask

  task automatic clocks(input int n, input int period);
    for (int k = 0; k < n; k++) begin
      chipEn = (k % period == 0);
      step();
    end
    chipEn = 0;
  endtask

  task automatic do_reset();
    reset = 1; chipEn = 0;
    step(); step();
    reset = 0;
    chips.delete();
    slip_acks = 0;
  endtask

  task automatic base_cfg(input bit gold);
    init = 18'h00001; polyTaps = 18'h20040; iOutTaps = 18'h00001; qOutTaps = 18'h00002;
    codeRestartCount = 18'd3; epoch = 18'd2; goldEnable = gold;
  endtask

  bit exp_i_plain [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
  bit exp_i_gold  [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  bit exp_q       [8] = '{0, 1, 0, 0, 0, 1, 0, 0};

  task automatic check_base_sequence(input bit gold);
    check("seq_len", chips.size(), 8);
    for (int k = 0; k < 8 && k < chips.size(); k++) begin
      check("seq_i",   chips[k].i,   gold ? exp_i_gold[k] : exp_i_plain[k]);
      check("seq_q",   chips[k].q,   exp_q[k]);
      check("seq_idx", chips[k].idx, k % 4);
      check("seq_ep",  chips[k].ep,  (k % 4) == 2);
    end
  endtask

  initial begin
    reset = 1; chipEn = 0; slip = 0;
    base_cfg(0);

    // Restart and output taps, then gold combine.
    do_reset();
    check("reset_valid", chipValid, 0);
    check("reset_index", chipIndex, 0);
    clocks(32, 4);
    check_base_sequence(0);
    base_cfg(1);
    do_reset();
    clocks(32, 4);
    check_base_sequence(1);

    // Feedback: after the 7th chip sr is 0x81, visible on the 8th chip.
    base_cfg(0);
    codeRestartCount = 18'h3FFFF; iOutTaps = 18'h00080; qOutTaps = 18'h00001;
    do_reset();
    clocks(32, 4);
    check("fb_len", chips.size(), 8);
    if (chips.size() == 8) begin
      check("fb_pre_i", chips[6].i, 0);
      check("fb_i",     chips[7].i, 1);
      check("fb_q",     chips[7].q, 1);
      check("fb_idx",   chips[7].idx, 7);
    end

    // Slip before chip 2, then hold the request 20 more clocks.
    base_cfg(0);
    do_reset();
    clocks(8, 4);
    chips.delete();
    slip = 1;
    step();
    clocks(12, 4);
    clocks(20, 4);
    check("slip_acks", slip_acks, 1);
    check("slip_chips", chips.size(), 7);
    if (chips.size() > 0) check("slip_resume_idx", chips[0].idx, 2);
    slip = 0;
    clocks(4, 4);

    // Slip pending at the restart chip: held, then restart happens late.
    do_reset();
    clocks(12, 4);
    slip = 1;
    step();
    chips.delete();
    clocks(12, 4);
    slip = 0;
    check("coll_len", chips.size(), 2);
    if (chips.size() == 2) begin
      check("coll_idx0", chips[0].idx, 3);
      check("coll_idx1", chips[1].idx, 0);
      check("coll_i1",   chips[1].i,   1);
    end

    // Reset while a slip is pending.
    do_reset();
    clocks(4, 4);
    slip = 1;
    step();
    slip = 0;
    reset = 1;
    step();
    check("rst_slip_valid", chipValid, 0);
    check("rst_slip_i",     iCode, 0);
    reset = 0;
    chips.delete();
    slip_acks = 0;
    clocks(20, 4);
    check("rst_slip_acks", slip_acks, 0);
    if (chips.size() > 0) begin
      check("rst_slip_idx", chips[0].idx, 0);
      check("rst_slip_i0",  chips[0].i, 1);
    end

    // Randomized traffic with a register-block style slip handshake.
    for (int seg = 0; seg < 4; seg++) begin
      int drop_wait;
      bit acked;
      init             = (seg == 1) ? 18'h0 : 18'($urandom);
      polyTaps         = 18'($urandom);
      iOutTaps         = 18'($urandom);
      qOutTaps         = 18'($urandom);
      codeRestartCount = (seg == 3) ? 18'd0 : 18'($urandom_range(1, 25));
      epoch            = 18'($urandom_range(0, 25));
      goldEnable       = 1'($urandom);
      do_reset();
      acked = 0; drop_wait = 0;
      for (int c = 0; c < 600; c++) begin
        if (c == 300 && seg != 3) codeRestartCount = 18'($urandom_range(0, 25));
        reset  = ($urandom_range(0, 399) == 0);
        chipEn = ($urandom_range(0, 2) == 0);
        if (!slip) begin
          if ($urandom_range(0, 39) == 0) begin slip = 1; acked = 0; end
        end else if (acked) begin
          if (drop_wait == 0) slip = 0; else drop_wait--;
        end
        step();
        if (e_slipped) begin acked = 1; drop_wait = $urandom_range(0, 6); end
      end
      reset = 0; slip = 0; chipEn = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
